// File: rtl/text_msg_rom.sv
// Multi-message character ROM with typewriter reveal: one registered character per lookup,
// uncovering the selected message one character per reveal tick with a cursor at the reveal point.
module text_msg_rom #(
    parameter int unsigned       N_MSG       = 4,
    parameter int unsigned       MSG_LEN     = 32,
    parameter int unsigned       ADDR_W      = 12,
    parameter int unsigned       CHAR_W      = 7,
    parameter int unsigned       REVEAL_DIV  = 2_000_000,
    parameter logic [CHAR_W-1:0] CURSOR_CHAR = 7'h5F,
    localparam int unsigned      SEL_W       = (N_MSG > 1) ? $clog2(N_MSG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  msg_sel,
    input  logic              restart,
    input  logic [ADDR_W-1:0] char_xy,
    output logic [CHAR_W-1:0] char_code,
    output logic              reveal_done
);

    localparam int unsigned CNT_W   = (MSG_LEN > 0) ? $clog2(MSG_LEN + 1) : 1;
    localparam int unsigned PRESC_W = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;
    localparam int unsigned CMP_W   = (ADDR_W > 32) ? ADDR_W : 32;
    localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(7'h20);

    localparam logic [28*8-1:0] MSG0 = "FOR SINGLE PLAYER TOGGLE SW1";
    localparam logic [26*8-1:0] MSG1 = "FOR MULTIPLAYER TOGGLE SW2";
    localparam logic [7*8-1:0]  MSG2 = "YOU WIN";
    localparam logic [8*8-1:0]  MSG3 = "YOU LOSE";

    typedef enum logic {REVEALING = 1'b0, DONE = 1'b1} state_t;

    // Message length per slot, clipped to the configured maximum
    function automatic int unsigned msg_len(input logic [SEL_W-1:0] s);
        int unsigned l;
        case (32'(s))
            0:       l = 28;
            1:       l = 26;
            2:       l = 7;
            3:       l = 8;
            default: l = 0;
        endcase
        return (l > MSG_LEN) ? MSG_LEN : l;
    endfunction

    // ASCII byte i of slot s; string literals hold the first character in the top byte
    function automatic logic [7:0] msg_byte(input logic [SEL_W-1:0] s, input int unsigned i);
        logic [7:0] b;
        b = 8'h20;
        case (32'(s))
            0: if (i < 28) b = MSG0[(27 - i)*8 +: 8];
            1: if (i < 26) b = MSG1[(25 - i)*8 +: 8];
            2: if (i < 7)  b = MSG2[(6 - i)*8 +: 8];
            3: if (i < 8)  b = MSG3[(7 - i)*8 +: 8];
            default: b = 8'h20;
        endcase
        return b;
    endfunction

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic [CNT_W-1:0]   reveal_cnt, cnt_nxt, cnt_inc;
    logic [SEL_W-1:0]   sel_q;
    logic [CHAR_W-1:0]  char_nxt;
    logic [CMP_W-1:0]   idx;
    int unsigned        cur_len;
    logic               do_restart;
    logic               tick;

    assign cur_len    = msg_len(msg_sel);
    assign do_restart = restart || (msg_sel != sel_q);
    assign tick       = (32'(presc) == REVEAL_DIV - 1);
    assign cnt_inc    = reveal_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= REVEALING;
        else     state <= state_nxt;
    end

    // Next state plus prescaler / reveal counter; restart beats a same-cycle tick
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        cnt_nxt   = reveal_cnt;
        if (do_restart) begin
            presc_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = (cur_len == 0) ? DONE : REVEALING;
        end else if (state == DONE) begin
            presc_nxt = '0;
            cnt_nxt   = CNT_W'(cur_len);
        end else if (32'(reveal_cnt) >= cur_len) begin
            presc_nxt = '0;
            cnt_nxt   = CNT_W'(cur_len);
            state_nxt = DONE;
        end else if (tick) begin
            presc_nxt = '0;
            cnt_nxt   = cnt_inc;
            if (32'(cnt_inc) == cur_len) state_nxt = DONE;
        end else begin
            presc_nxt = presc + PRESC_W'(1);
        end
    end

    // Character lookup against the pre-update reveal state
    always_comb begin
        char_nxt = BLANK;
        idx      = CMP_W'(char_xy);
        if (idx >= CMP_W'(cur_len) || idx >= CMP_W'(MSG_LEN))
            char_nxt = BLANK;
        else if (state == REVEALING && idx == CMP_W'(reveal_cnt))
            char_nxt = CURSOR_CHAR;
        else if (state == REVEALING && idx > CMP_W'(reveal_cnt))
            char_nxt = BLANK;
        else
            char_nxt = CHAR_W'(msg_byte(msg_sel, 32'(char_xy)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            reveal_cnt  <= '0;
            sel_q       <= '0;
            char_code   <= BLANK;
            reveal_done <= 1'b0;
        end else begin
            presc       <= presc_nxt;
            reveal_cnt  <= cnt_nxt;
            sel_q       <= msg_sel;
            char_code   <= char_nxt;
            reveal_done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_text_msg_rom.sv
// Scoreboard bench for text_msg_rom: stimulus queues expected outputs per cycle,
// a monitor pops and compares them just after each rising edge.
module tb_text_msg_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic [1:0]  a_sel;
    logic [2:0]  b_sel;
    logic [11:0] a_xy, b_xy;
    logic [6:0]  a_code, b_code;
    logic        a_done, b_done;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    int         q_due[$];
    int         q_sig[$];
    logic [6:0] q_exp[$];
    string      q_name[$];

    logic [6:0] you_win [8] = '{7'h59, 7'h4F, 7'h55, 7'h20, 7'h57, 7'h49, 7'h4E, 7'h20};

    always #5 clk = ~clk;

    text_msg_rom #(.N_MSG(4), .REVEAL_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .msg_sel(a_sel), .restart(restart),
        .char_xy(a_xy), .char_code(a_code), .reveal_done(a_done)
    );

    text_msg_rom #(.N_MSG(8), .REVEAL_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .msg_sel(b_sel), .restart(1'b0),
        .char_xy(b_xy), .char_code(b_code), .reveal_done(b_done)
    );

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // sig: 0 a_code, 1 a_done, 2 b_code, 3 b_done; checked after the next rising edge
    task automatic push(input int sig, input logic [6:0] e, input string nm);
        q_due.push_back(cyc + 1);
        q_sig.push_back(sig);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [6:0] act;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q_due.size() > 0 && q_due[0] <= cyc) begin
                case (q_sig[0])
                    0:       act = a_code;
                    1:       act = {6'd0, a_done};
                    2:       act = b_code;
                    default: act = {6'd0, b_done};
                endcase
                check(q_name[0], 12'(act), 12'(q_exp[0]));
                void'(q_due.pop_front());
                void'(q_sig.pop_front());
                void'(q_exp.pop_front());
                void'(q_name.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; restart = 1'b0; a_sel = 2'd2; b_sel = 3'd5; a_xy = '0; b_xy = '0;
        wait_n(3);
        check("rst_code_a", 12'(a_code), 12'h020);
        check("rst_done_a", 12'(a_done), 12'h000);

        // Slot 2 reveal; restart fires on the first edge since sel_q resets to 0
        rst = 1'b0;
        push(0, 7'h5F, "a_first_cursor");
        push(1, 7'h00, "a_done_start");
        push(2, 7'h20, "b_blank_idx0");
        push(3, 7'h01, "b_done_empty_slot");
        wait_n(5);
        a_xy = 12'd1; b_xy = 12'hFFF;
        push(0, 7'h5F, "a_cursor_idx1");
        push(2, 7'h20, "b_blank_fff");
        wait_n(1); a_xy = 12'd0; push(0, 7'h59, "a_idx0_revealed");
        wait_n(1); a_xy = 12'd2; push(0, 7'h20, "a_idx2_hidden");
        wait_n(20); push(1, 7'h00, "a_done_early");
        wait_n(1); a_xy = 12'd6;
        push(0, 7'h5F, "a_cursor_idx6");
        push(1, 7'h01, "a_done_rise");
        for (int i = 0; i < 8; i++) begin
            wait_n(1); a_xy = 12'(i); push(0, you_win[i], "a_you_win");
        end

        // Slot 0, 12 cycles after restart: reveal_cnt = 3
        wait_n(1); a_sel = 2'd0;
        wait_n(1);
        wait_n(12); a_xy = 12'd2; push(0, 7'h52, "a_mid_idx2_R");
        wait_n(1);  a_xy = 12'd3; push(0, 7'h5F, "a_mid_idx3_cursor");
        wait_n(1);  a_xy = 12'd4; push(0, 7'h20, "a_mid_idx4_blank");

        // Slot 3 to DONE, then restart pulse and full re-reveal of 32 cycles
        wait_n(1); a_sel = 2'd3;
        wait_n(1);
        wait_n(31); push(1, 7'h01, "a_done_slot3");
        wait_n(2);
        restart = 1'b1; a_xy = 12'd0;
        push(0, 7'h59, "a_done_lookup_Y");
        push(1, 7'h00, "a_done_fall_restart");
        wait_n(1); restart = 1'b0; push(0, 7'h5F, "a_restart_cursor");
        wait_n(30); push(1, 7'h00, "a_redone_early");
        wait_n(1);  push(1, 7'h01, "a_redone");

        // Held restart pins the reveal at index 0
        wait_n(2); restart = 1'b1;
        wait_n(8); a_xy = 12'd1; push(0, 7'h20, "a_hold_blank");
        wait_n(1); a_xy = 12'd0;
        push(0, 7'h5F, "a_hold_cursor");
        push(1, 7'h00, "a_hold_done");
        wait_n(1); restart = 1'b0;

        // Slot 0 to DONE, then switch to slot 1
        wait_n(1); a_sel = 2'd0;
        wait_n(1);
        wait_n(111); push(1, 7'h01, "a_done_slot0");
        wait_n(2); a_sel = 2'd1; a_xy = 12'd25;
        push(1, 7'h00, "a_done_drop_sel");
        wait_n(1);
        wait_n(103);
        push(0, 7'h5F, "a_cursor_idx25");
        push(1, 7'h01, "a_done_slot1");
        wait_n(1); push(0, 7'h32, "a_idx25_2");

        // Asynchronous reset mid-reveal
        wait_n(1); restart = 1'b1; a_xy = 12'd0;
        wait_n(1); restart = 1'b0;
        wait_n(10);
        #2 rst = 1'b1;
        #1;
        check("async_code_a", 12'(a_code), 12'h020);
        check("async_done_b", 12'(b_done), 12'h000);
        wait_n(2);
        rst = 1'b0;
        push(0, 7'h5F, "a_rst_cursor0");
        push(3, 7'h01, "b_done_after_rst");
        wait_n(5); a_xy = 12'd1; push(0, 7'h5F, "a_rst_cursor1");
        wait_n(1); a_xy = 12'd0; push(0, 7'h46, "a_rst_idx0_F");
        wait_n(3);

        check("queue_drained", 12'(q_due.size()), 12'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
